// File: rtl/morse_pkg.sv
// Shared definitions for the Morse digit path.
// Holds the sequencer state encoding and the symbol/timing constants.
// These are used by the digit ROM and by the sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int   SYMBOLS     = 5;
  localparam logic DOT         = 1'b0;
  localparam logic DASH        = 1'b1;
  localparam int   DOT_UNITS   = 1;
  localparam int   DASH_UNITS  = 3;
  localparam int   SPACE_UNITS = 1;
  localparam int   GAP_UNITS   = 3;

endpackage

// File: rtl/morse_digit_rom.sv
// Digit-to-Morse lookup table.
// Ports:
//   digit   in  [3:0] BCD digit
//   pattern out [4:0] symbol i in bit i (bit 0 is sent first), 1 = dash
//   valid   out       1 when digit is 0..9
// The conversion path uses this same table.
module morse_digit_rom
  import morse_pkg::*;
(
  input  logic [3:0] digit,
  output logic [4:0] pattern,
  output logic       valid
);

  always_comb begin
    pattern = 5'b00000;
    valid   = 1'b1;
    // Literals are written with symbol 4 on the left, symbol 0 on the right.
    case (digit)
      4'd0:    pattern = 5'b11111;
      4'd1:    pattern = 5'b11110;
      4'd2:    pattern = 5'b11100;
      4'd3:    pattern = 5'b11000;
      4'd4:    pattern = 5'b10000;
      4'd5:    pattern = 5'b00000;
      4'd6:    pattern = 5'b00001;
      4'd7:    pattern = 5'b00011;
      4'd8:    pattern = 5'b00111;
      4'd9:    pattern = 5'b01111;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_digit_sequencer.sv
// Keys one BCD digit out as Morse code with standard unit timing.
// Ports:
//   clock     in   rising-edge system clock
//   reset     in   synchronous, active-high reset
//   start     in   transmit request, accepted only while ready=1
//   digit     in   [3:0] BCD digit, sampled on the accepting edge
//   ready     out  idle and able to accept start
//   busy      out  digit is being keyed (marks, spaces and final gap)
//   key_out   out  Morse line, 1 = mark
//   done      out  one-cycle pulse after the final gap
//   error     out  one-cycle pulse when start is seen with digit > 9
//   state_dbg out  current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where start=1 and ready=1.
// start is ignored while ready=0; it is never queued.
module morse_digit_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] digit,
  output logic       ready,
  output logic       busy,
  output logic       key_out,
  output logic       done,
  output logic       error,
  output state_t     state_dbg
);

  // Last count value for each timed interval; the counter runs 0..last.
  localparam logic [CNT_W-1:0] DOT_LAST   = CNT_W'(DOT_UNITS   * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST  = CNT_W'(DASH_UNITS  * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(SPACE_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_UNITS   * UNIT_CYCLES - 1);
  localparam logic [2:0]       SYM_LAST   = 3'(SYMBOLS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sym_idx;
  logic [4:0]       pattern;
  logic [4:0]       rom_pattern;
  logic             rom_valid;
  logic [CNT_W-1:0] mark_last;

  morse_digit_rom u_rom (
    .digit   (digit),
    .pattern (rom_pattern),
    .valid   (rom_valid)
  );

  assign mark_last = (pattern[sym_idx] == DASH) ? DASH_LAST : DOT_LAST;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sym_idx <= '0;
      pattern <= '0;
      key_out <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (rom_valid) begin
              pattern <= rom_pattern;
              sym_idx <= '0;
              cnt     <= '0;
              state   <= MARK;
              key_out <= 1'b1;
              busy    <= 1'b1;
              ready   <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        MARK: begin
          if (cnt == mark_last) begin
            cnt     <= '0;
            key_out <= 1'b0;
            state   <= (sym_idx == SYM_LAST) ? GAP : SPACE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SPACE: begin
          if (cnt == SPACE_LAST) begin
            cnt     <= '0;
            sym_idx <= sym_idx + 3'd1;
            key_out <= 1'b1;
            state   <= MARK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          // Returning to IDLE with ready=1 in the done cycle lets a start
          // presented alongside done be accepted on the very next edge.
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
